// File: rtl/ahb_mtx_out_stg_rr.sv
// ahb_mtx_out_stg_rr: AHB-Lite bus-matrix output stage with an integrated
// round-robin arbiter, defined-length burst tracking and locked-sequence
// retention. One instance per slave.
// Optional feature macro: AHB_MTX_USER_EN adds HAUSER/HWUSER side-band routing.
module ahb_mtx_out_stg_rr #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
`ifdef AHB_MTX_USER_EN
    , parameter int USER_W  = 32
`endif
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [NUM_PORTS-1:0]        sel_op,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_op,
    input  logic [NUM_PORTS*2-1:0]      trans_op,
    input  logic [NUM_PORTS-1:0]        write_op,
    input  logic [NUM_PORTS*3-1:0]      size_op,
    input  logic [NUM_PORTS*3-1:0]      burst_op,
    input  logic [NUM_PORTS*4-1:0]      prot_op,
    input  logic [NUM_PORTS*4-1:0]      master_op,
    input  logic [NUM_PORTS-1:0]        mastlock_op,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata_op,
    input  logic [NUM_PORTS-1:0]        held_tran_op,
    input  logic                        HREADYOUTM,
    output logic [NUM_PORTS-1:0]        active_op,
    output logic                        HSELM,
    output logic [ADDR_W-1:0]           HADDRM,
    output logic [1:0]                  HTRANSM,
    output logic                        HWRITEM,
    output logic [2:0]                  HSIZEM,
    output logic [2:0]                  HBURSTM,
    output logic [3:0]                  HPROTM,
    output logic [3:0]                  HMASTERM,
    output logic                        HMASTLOCKM,
    output logic                        HREADYMUXM,
    output logic [DATA_W-1:0]           HWDATAM
`ifdef AHB_MTX_USER_EN
    , input  logic [NUM_PORTS*USER_W-1:0] auser_op
    , input  logic [NUM_PORTS*USER_W-1:0] wuser_op
    , output logic [USER_W-1:0]           HAUSERM
    , output logic [USER_W-1:0]           HWUSERM
`endif
);

    localparam int         NSLOT     = 1 << PORT_W;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_INCR   = 3'b001;

    logic [PORT_W-1:0] grant_port_q, grant_port_d;
    logic [PORT_W-1:0] last_port_q, last_port_d;
    logic [PORT_W-1:0] data_in_port_q, data_in_port_d;
    logic              no_port_q, no_port_d;
    logic              hsel_lock_q, hsel_lock_d;
    logic              slave_sel_q, slave_sel_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;

    logic [NSLOT-1:0]  req;
    logic [3:0]        beat_nxt;
    logic              addr_en, hold, hlock_arb, found;
    logic [PORT_W:0]   scan;
    logic [PORT_W-1:0] wdata_sel;

    // Address phase is blanked while parked or in reset.
    assign addr_en    = ~no_port_q & ~HRESET;
    assign HREADYMUXM = (slave_sel_q & ~HRESET) ? HREADYOUTM : 1'b1;
    assign wdata_sel  = HRESET ? '0 : data_in_port_q;

    // Per-port request: a port must both select this slave and hold a transfer.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++) req[i] = held_tran_op[i] & sel_op[i];
    end

    // Address-phase mux driven from the registered grant.
    always_comb begin
        active_op  = '0;
        HSELM      = 1'b0;
        HADDRM     = '0;
        HTRANSM    = TR_IDLE;
        HWRITEM    = 1'b0;
        HSIZEM     = '0;
        HBURSTM    = '0;
        HPROTM     = '0;
        HMASTERM   = '0;
        HMASTLOCKM = 1'b0;
`ifdef AHB_MTX_USER_EN
        HAUSERM    = '0;
`endif
        if (addr_en) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (PORT_W'(i) == grant_port_q) begin
                    active_op[i] = 1'b1;
                    HSELM        = sel_op[i];
                    HADDRM       = addr_op[i*ADDR_W +: ADDR_W];
                    HTRANSM      = trans_op[i*2 +: 2];
                    HWRITEM      = write_op[i];
                    HSIZEM       = size_op[i*3 +: 3];
                    HBURSTM      = burst_op[i*3 +: 3];
                    HPROTM       = prot_op[i*4 +: 4];
                    HMASTERM     = master_op[i*4 +: 4];
                    HMASTLOCKM   = mastlock_op[i];
`ifdef AHB_MTX_USER_EN
                    HAUSERM      = auser_op[i*USER_W +: USER_W];
`endif
                end
            end
        end
    end

    // Data-phase mux follows the port that owned the previous address phase.
    always_comb begin
        HWDATAM = '0;
`ifdef AHB_MTX_USER_EN
        HWUSERM = '0;
`endif
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (PORT_W'(i) == wdata_sel) begin
                HWDATAM = wdata_op[i*DATA_W +: DATA_W];
`ifdef AHB_MTX_USER_EN
                HWUSERM = wuser_op[i*USER_W +: USER_W];
`endif
            end
        end
    end

    // Burst/lock hold evaluation and round-robin arbitration.
    always_comb begin
        grant_port_d   = grant_port_q;
        last_port_d    = last_port_q;
        data_in_port_d = data_in_port_q;
        no_port_d      = no_port_q;
        hsel_lock_d    = hsel_lock_q;
        slave_sel_d    = slave_sel_q;
        beat_cnt_d     = beat_cnt_q;
        found          = 1'b0;
        scan           = '0;

        // Remaining beats after this cycle, assuming the transfer is accepted.
        beat_nxt = beat_cnt_q;
        if (HSELM && HTRANSM == TR_NONSEQ) begin
            case (HBURSTM)
                3'b010, 3'b011: beat_nxt = 4'd3;
                3'b100, 3'b101: beat_nxt = 4'd7;
                3'b110, 3'b111: beat_nxt = 4'd15;
                default:        beat_nxt = 4'd0;
            endcase
        end else if (HSELM && HTRANSM == TR_SEQ && beat_cnt_q != 4'd0) begin
            beat_nxt = beat_cnt_q - 4'd1;
        end

        hlock_arb = HMASTLOCKM & (hsel_lock_q | HSELM);
        hold      = (beat_nxt != 4'd0)
                  | ((HBURSTM == BU_INCR) && (HTRANSM != TR_IDLE) && req[grant_port_q])
                  | hlock_arb;

        if (HREADYMUXM) begin
            beat_cnt_d     = beat_nxt;
            data_in_port_d = grant_port_q;
            slave_sel_d    = HSELM;
            if (HSELM & HTRANSM[1] & HMASTLOCKM) hsel_lock_d = 1'b1;
            else if (!HMASTLOCKM)                hsel_lock_d = 1'b0;

            if (!hold) begin
                // Scan starts one past the last winner so every port gets a turn.
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    scan = {1'b0, last_port_q} + (PORT_W+1)'(k);
                    if (scan >= (PORT_W+1)'(NUM_PORTS)) scan = scan - (PORT_W+1)'(NUM_PORTS);
                    if (!found && req[scan[PORT_W-1:0]]) begin
                        found        = 1'b1;
                        grant_port_d = scan[PORT_W-1:0];
                    end
                end
                no_port_d = ~found;
                if (found) last_port_d = grant_port_d;
            end
        end
    end

    // State registers; reset abandons any burst or locked sequence in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_port_q   <= '0;
            no_port_q      <= 1'b1;
            last_port_q    <= PORT_W'(NUM_PORTS - 1);
            beat_cnt_q     <= '0;
            hsel_lock_q    <= 1'b0;
            slave_sel_q    <= 1'b0;
            data_in_port_q <= '0;
        end else begin
            grant_port_q   <= grant_port_d;
            no_port_q      <= no_port_d;
            last_port_q    <= last_port_d;
            beat_cnt_q     <= beat_cnt_d;
            hsel_lock_q    <= hsel_lock_d;
            slave_sel_q    <= slave_sel_d;
            data_in_port_q <= data_in_port_d;
        end
    end

endmodule

// File: tb/tb_ahb_mtx_out_stg_rr.sv
// Directed bench for ahb_mtx_out_stg_rr: a vector table for reset, grant
// latency and rotation, then hand sequences for burst, lock, data-phase
// and mid-burst reset corner cases.
module tb_ahb_mtx_out_stg_rr;

    localparam int NP = 4;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [NP-1:0]   sel_op, write_op, mastlock_op, held_tran_op;
    logic [NP*32-1:0] addr_op, wdata_op;
    logic [NP*2-1:0] trans_op;
    logic [NP*3-1:0] size_op, burst_op;
    logic [NP*4-1:0] prot_op, master_op;
    logic            HREADYOUTM;
    logic [NP-1:0]   active_op;
    logic            HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
    logic [31:0]     HADDRM, HWDATAM;
    logic [1:0]      HTRANSM;
    logic [2:0]      HSIZEM, HBURSTM;
    logic [3:0]      HPROTM, HMASTERM;
`ifdef AHB_MTX_USER_EN
    logic [NP*32-1:0] auser_op, wuser_op;
    logic [31:0]      HAUSERM, HWUSERM;
    assign auser_op = '0;
    assign wuser_op = '0;
`endif

    ahb_mtx_out_stg_rr #(.NUM_PORTS(NP), .PORT_W(2), .ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .sel_op(sel_op), .addr_op(addr_op),
        .trans_op(trans_op), .write_op(write_op), .size_op(size_op),
        .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
        .mastlock_op(mastlock_op), .wdata_op(wdata_op), .held_tran_op(held_tran_op),
        .HREADYOUTM(HREADYOUTM), .active_op(active_op), .HSELM(HSELM),
        .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
        .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM),
        .HMASTLOCKM(HMASTLOCKM), .HREADYMUXM(HREADYMUXM), .HWDATAM(HWDATAM)
`ifdef AHB_MTX_USER_EN
        , .auser_op(auser_op), .wuser_op(wuser_op), .HAUSERM(HAUSERM), .HWUSERM(HWUSERM)
`endif
    );

    always #5 HCLK = ~HCLK;

    // Per-port stimulus, packed onto the flat buses below.
    logic [NP-1:0] t_sel, t_held, t_write, t_lock;
    logic [1:0]    t_trans [NP];
    logic [2:0]    t_burst [NP];
    logic [31:0]   t_addr  [NP];
    logic [31:0]   t_wdata [NP];

    // Pack per-port stimulus onto the DUT's flat buses.
    always_comb begin
        sel_op = '0; held_tran_op = '0; write_op = '0; mastlock_op = '0;
        addr_op = '0; wdata_op = '0; trans_op = '0; size_op = '0;
        burst_op = '0; prot_op = '0; master_op = '0;
        for (int i = 0; i < NP; i++) begin
            sel_op[i]             = t_sel[i];
            held_tran_op[i]       = t_held[i];
            write_op[i]           = t_write[i];
            mastlock_op[i]        = t_lock[i];
            addr_op[i*32 +: 32]   = t_addr[i];
            wdata_op[i*32 +: 32]  = t_wdata[i];
            trans_op[i*2 +: 2]    = t_trans[i];
            size_op[i*3 +: 3]     = 3'd2;
            burst_op[i*3 +: 3]    = t_burst[i];
            prot_op[i*4 +: 4]     = 4'h3;
            master_op[i*4 +: 4]   = 4'(i);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic [1:0] tr,
                            input logic [2:0] bu, input logic wr, input logic lk);
        t_sel[p] = r; t_held[p] = r; t_trans[p] = r ? tr : IDLE;
        t_burst[p] = bu; t_write[p] = wr; t_lock[p] = lk;
    endtask

    task automatic idle_all;
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, IDLE, SINGLE, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        HRESET = 1'b1; HREADYOUTM = 1'b1; idle_all();
        #1; tick(); HRESET = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [3:0]  act;
        logic        hsel;
        logic        mux;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl [15];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        for (int p = 0; p < NP; p++) begin
            t_addr[p]  = 32'h1000_0000 + 32'h100 * p;
            t_wdata[p] = 32'hD0D0_0000 + p;
        end
        HRESET = 1'b1; HREADYOUTM = 1'b1; idle_all();

        //          rst   req      rdy   act      hsel  mux   addr
        tbl[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0};
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 32'h1000_0200};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b1, 32'h1000_0200};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 32'h1000_0000};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 32'h1000_0100};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 32'h1000_0200};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 32'h1000_0300};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 32'h1000_0000};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 32'h1000_0100};
        tbl[12] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 32'h1000_0100};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 32'h1000_0100};
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 32'h1000_0200};

        for (int r = 0; r < 15; r++) begin
            HRESET     = tbl[r].rst;
            HREADYOUTM = tbl[r].rdy;
            for (int p = 0; p < NP; p++) set_port(p, tbl[r].req[p], NONSEQ, SINGLE, 1'b0, 1'b0);
            #1;
            chk($sformatf("vec%0d_active", r), active_op, tbl[r].act);
            chk($sformatf("vec%0d_hsel", r), HSELM, tbl[r].hsel);
            chk($sformatf("vec%0d_readymux", r), HREADYMUXM, tbl[r].mux);
            chk($sformatf("vec%0d_haddr", r), HADDRM, tbl[r].addr);
            tick();
        end

        // INCR4 with a two-cycle wait on beat 2; port 0 waits for the full burst.
        do_reset();
        set_port(1, 1'b1, NONSEQ, INCR4, 1'b0, 1'b0); #1; tick();
        set_port(0, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0); #1;
        chk("incr4_b1_active", active_op, 4'b0010);
        chk("incr4_b1_trans", HTRANSM, NONSEQ);
        tick();
        t_trans[1] = SEQ; HREADYOUTM = 1'b0; #1;
        chk("incr4_wait1_active", active_op, 4'b0010);
        chk("incr4_wait1_mux", HREADYMUXM, 1'b0);
        tick(); #1;
        chk("incr4_wait2_active", active_op, 4'b0010);
        chk("incr4_wait2_mux", HREADYMUXM, 1'b0);
        tick();
        HREADYOUTM = 1'b1; #1;
        chk("incr4_b2_active", active_op, 4'b0010);
        tick(); #1;
        chk("incr4_b3_active", active_op, 4'b0010);
        tick(); #1;
        chk("incr4_b4_active", active_op, 4'b0010);
        tick(); #1;
        chk("incr4_after_active", active_op, 4'b0001);
        chk("incr4_after_addr", HADDRM, 32'h1000_0000);

        // Locked INCR from port 3 survives dropped HSEL and locked IDLE.
        do_reset();
        set_port(3, 1'b1, NONSEQ, INCR, 1'b0, 1'b1); #1; tick();
        set_port(0, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
        set_port(1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0); #1;
        chk("lock_d1_active", active_op, 4'b1000);
        chk("lock_d1_mastlock", HMASTLOCKM, 1'b1);
        tick();
        t_trans[3] = SEQ; #1;
        chk("lock_d2_active", active_op, 4'b1000);
        tick();
        t_sel[3] = 1'b0; #1;
        chk("lock_nosel1_active", active_op, 4'b1000);
        chk("lock_nosel1_hsel", HSELM, 1'b0);
        tick(); #1;
        chk("lock_nosel2_active", active_op, 4'b1000);
        tick();
        t_sel[3] = 1'b1; t_trans[3] = IDLE; #1;
        chk("lock_idle_active", active_op, 4'b1000);
        tick();
        t_lock[3] = 1'b0; #1;
        chk("lock_release_active", active_op, 4'b1000);
        tick(); #1;
        chk("lock_after_active", active_op, 4'b0001);

        // Write data follows the data-phase owner, not the new grant.
        do_reset();
        set_port(2, 1'b1, NONSEQ, SINGLE, 1'b1, 1'b0); #1; tick();
        set_port(0, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0); #1;
        chk("wdata_e1_active", active_op, 4'b0100);
        chk("wdata_e1_hwrite", HWRITEM, 1'b1);
        tick();
        set_port(2, 1'b0, IDLE, SINGLE, 1'b0, 1'b0); #1;
        chk("wdata_e2_active", active_op, 4'b0001);
        chk("wdata_e2_hwdata", HWDATAM, 32'hD0D0_0002);

        // Reset on beat 2 of INCR8, then a fresh NONSEQ reloads the counter.
        do_reset();
        set_port(1, 1'b1, NONSEQ, INCR8, 1'b1, 1'b0); #1; tick(); #1;
        chk("rst8_f1_active", active_op, 4'b0010);
        tick();
        t_trans[1] = SEQ; HRESET = 1'b1; HREADYOUTM = 1'b0; #1;
        chk("rst8_in_hsel", HSELM, 1'b0);
        chk("rst8_in_trans", HTRANSM, IDLE);
        chk("rst8_in_mux", HREADYMUXM, 1'b1);
        chk("rst8_in_active", active_op, 4'b0000);
        chk("rst8_in_hwdata", HWDATAM, 32'hD0D0_0000);
        tick();
        HRESET = 1'b0; HREADYOUTM = 1'b1; t_trans[1] = NONSEQ; #1;
        chk("rst8_after_hsel", HSELM, 1'b0);
        chk("rst8_after_mux", HREADYMUXM, 1'b1);
        chk("rst8_after_cnt", dut.beat_cnt_q, 4'd0);
        tick(); #1;
        chk("rst8_fresh_active", active_op, 4'b0010);
        chk("rst8_fresh_trans", HTRANSM, NONSEQ);
        tick(); #1;
        chk("rst8_fresh_cnt", dut.beat_cnt_q, 4'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
